// File: rtl/issue_queue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_queue_ctrl_if
// Description : Fetcher / decoder / dispatch handshake bundle for the
//               instruction issue queue. The statistics outputs exist only
//               when ISSUE_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface issue_queue_ctrl_if;
    // fetcher side
    logic        in_fetcher_valid;
    logic [31:0] in_fetcher_inst;
    logic [31:0] in_fetcher_pc;
    logic        in_fetcher_jump_flag;
    logic        out_fetcher_full;
    // decoder side
    logic [31:0] out_decoder_inst;
    logic [31:0] out_decoder_pc;
    logic        out_decoder_jump_flag;
    // dispatch resources
    logic        in_rob_full;
    logic        in_rs_full;
    logic        in_lsb_full;
    logic        in_rob_rollback;
    logic        out_issue_valid;
    logic        out_rob_issue;
    logic        out_rs_issue;
    logic        out_lsb_issue;
`ifdef ISSUE_STATS_EN
    logic [31:0] out_stat_issued;
    logic [31:0] out_stat_stall;
`endif

    // queue side
    modport slave (
        input  in_fetcher_valid, in_fetcher_inst, in_fetcher_pc, in_fetcher_jump_flag,
        output out_fetcher_full,
        output out_decoder_inst, out_decoder_pc, out_decoder_jump_flag,
        input  in_rob_full, in_rs_full, in_lsb_full, in_rob_rollback,
        output out_issue_valid, out_rob_issue, out_rs_issue, out_lsb_issue
`ifdef ISSUE_STATS_EN
        , output out_stat_issued, out_stat_stall
`endif
    );

    // environment side
    modport master (
        output in_fetcher_valid, in_fetcher_inst, in_fetcher_pc, in_fetcher_jump_flag,
        input  out_fetcher_full,
        input  out_decoder_inst, out_decoder_pc, out_decoder_jump_flag,
        output in_rob_full, in_rs_full, in_lsb_full, in_rob_rollback,
        input  out_issue_valid, out_rob_issue, out_rs_issue, out_lsb_issue
`ifdef ISSUE_STATS_EN
        , input out_stat_issued, out_stat_stall
`endif
    );
endinterface
`default_nettype wire

// File: rtl/issue_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : issue_queue_ctrl
// Description : Circular instruction queue between fetcher and decoder with a
//               single-issue scheduler gated by ROB / RS / LSB space. Rollback
//               drains the queue. Optional macro ISSUE_STATS_EN adds saturating
//               issued / stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_queue_ctrl #(
    parameter int IQ_ADDR_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    issue_queue_ctrl_if.slave  bus
);

    localparam int                 c_ENTRIES   = 1 << IQ_ADDR_WIDTH;
    localparam logic [IQ_ADDR_WIDTH:0] c_DEPTH     = {1'b1, {IQ_ADDR_WIDTH{1'b0}}};
    localparam logic [IQ_ADDR_WIDTH:0] c_FULL_MARK = {1'b0, {IQ_ADDR_WIDTH{1'b1}}};

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    logic [IQ_ADDR_WIDTH-1:0] r_head;
    logic [IQ_ADDR_WIDTH-1:0] r_tail;
    logic [IQ_ADDR_WIDTH:0]   r_count;
    logic                     r_full;

    logic [31:0] r_inst [c_ENTRIES];
    logic [31:0] r_pc   [c_ENTRIES];
    logic        r_jump [c_ENTRIES];

    logic                   w_empty;
    logic [31:0]            w_head_inst;
    logic                   w_to_lsb;
    logic                   w_to_rs;
    logic                   w_illegal;
    logic                   w_target_ok;
    logic                   w_pop;
    logic                   w_push;
    logic [IQ_ADDR_WIDTH:0] w_count_nxt;

    assign w_empty     = (r_count == '0);
    assign w_head_inst = r_inst[r_head];

    // Head entry routing by opcode; anything unrecognised is dropped
    always_comb begin
        w_to_lsb  = 1'b0;
        w_to_rs   = 1'b0;
        w_illegal = 1'b0;
        case (w_head_inst[6:0])
            c_OP_LOAD, c_OP_STORE:                      w_to_lsb  = 1'b1;
            c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR,
            c_OP_BRANCH, c_OP_IMM, c_OP_REG:            w_to_rs   = 1'b1;
            default:                                    w_illegal = 1'b1;
        endcase
    end

    // Illegal heads are dropped regardless of downstream space
    assign w_target_ok = w_illegal
                       | (~bus.in_rob_full & (w_to_lsb ? ~bus.in_lsb_full : ~bus.in_rs_full));
    assign w_pop       = rdy & ~rst & ~bus.in_rob_rollback & ~w_empty & w_target_ok;
    assign w_push      = bus.in_fetcher_valid & rdy & ~bus.in_rob_rollback & (r_count != c_DEPTH);
    assign w_count_nxt = r_count + {{IQ_ADDR_WIDTH{1'b0}}, w_push}
                                 - {{IQ_ADDR_WIDTH{1'b0}}, w_pop};

    assign bus.out_issue_valid = w_pop;
    assign bus.out_rob_issue   = w_pop & ~w_illegal;
    assign bus.out_rs_issue    = w_pop & w_to_rs;
    assign bus.out_lsb_issue   = w_pop & w_to_lsb;

    assign bus.out_decoder_inst      = w_empty ? 32'h0 : w_head_inst;
    assign bus.out_decoder_pc        = w_empty ? 32'h0 : r_pc[r_head];
    assign bus.out_decoder_jump_flag = w_empty ? 1'b0  : r_jump[r_head];
    assign bus.out_fetcher_full      = r_full;

    // Pointer / occupancy bookkeeping; rollback empties the queue outright
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (rdy) begin
            if (bus.in_rob_rollback) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_full  <= 1'b0;
            end else begin
                if (w_pop)  r_head <= r_head + 1'b1;
                if (w_push) r_tail <= r_tail + 1'b1;
                r_count <= w_count_nxt;
                // one slot of slack covers a fetch already in flight
                r_full  <= (w_count_nxt >= c_FULL_MARK);
            end
        end
    end

    // Entry storage; written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst[r_tail] <= bus.in_fetcher_inst;
            r_pc[r_tail]   <= bus.in_fetcher_pc;
            r_jump[r_tail] <= bus.in_fetcher_jump_flag;
        end
    end

`ifdef ISSUE_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_stall;

    // Saturating issue / stall counters, untouched by rollback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else if (rdy) begin
            if (w_pop && !w_illegal && r_stat_issued != 32'hFFFF_FFFF)
                r_stat_issued <= r_stat_issued + 32'd1;
            if (!w_empty && !bus.in_rob_rollback && !w_pop && r_stat_stall != 32'hFFFF_FFFF)
                r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign bus.out_stat_issued = r_stat_issued;
    assign bus.out_stat_stall  = r_stat_stall;
`endif

endmodule
`default_nettype wire
